// File: rtl/cu_seq_pkg.sv
// Shared types for the control_unit operation sequencer: operation codes,
// the buffered command record and the sequencer FSM states.
package cu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [3:0] a;
        logic [3:0] b;
    } cu_cmd_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_e;

    localparam int CMD_W = $bits(cu_cmd_t);

    // True when the 8-bit result is just the sign extension of its low nibble,
    // i.e. the value still fits a signed 4-bit number.
    function automatic logic sign_fits(input logic [3:0] hi, input logic lo_msb);
        return (hi == {4{lo_msb}});
    endfunction

    // Only the adder-based operations produce a meaningful carry-out.
    function automatic logic op_has_carry(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cu_cmd_fifo.sv
// Command FIFO for the sequencer. Pointers carry one extra MSB so full and
// empty are told apart without a separate occupancy counter. The head is
// read straight from storage and forced to zero whenever the FIFO is empty.
module cu_cmd_fifo
    import cu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  cu_cmd_t i_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output cu_cmd_t o_head
);

    localparam int AW = $clog2(DEPTH);

    cu_cmd_t       r_mem [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;

    logic [AW-1:0] w_wrIdx;
    logic [AW-1:0] w_rdIdx;
    logic          w_doPush;
    logic          w_doPop;

    assign w_wrIdx  = r_wrPtr[AW-1:0];
    assign w_rdIdx  = r_rdPtr[AW-1:0];

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (w_wrIdx == w_rdIdx);

    // A pop frees the head slot in the same cycle, so a push is still
    // accepted at full occupancy when it coincides with a pop.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    assign o_head   = o_empty ? cu_cmd_t'('0) : r_mem[w_rdIdx];

    // Storage write; contents need no reset because an empty FIFO masks the head.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[w_wrIdx] <= i_data;
        end
    end

    // Pointer update; reset empties the FIFO and discards anything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cu_op_sequencer.sv
// Sequential front end for the combinational control_unit. Commands are
// buffered in a FIFO, the head is presented on the cu_* outputs, and the
// control_unit results are captured into a valid/ready response register
// together with locally derived zero/overflow/carry flags.
//
// Build option CU_OVF_HALT_EN: when defined, capturing an overflowing result
// halts issue until halt_clr is pulsed. When undefined the sequencer never
// halts, halted is tied low and halt_clr is ignored.
module cu_op_sequencer
    import cu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,

    output logic             cu_ctrl1,
    output logic             cu_ctrl0,
    output logic [3:0]       cu_a,
    output logic [3:0]       cu_b,
    input  logic [3:0]       cu_resh,
    input  logic [3:0]       cu_resl,
    input  logic             cu_zero,
    input  logic             cu_ovf,
    input  logic             cu_cout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [7:0]       rsp_res,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_cout,

    output logic [CNT_W-1:0] issued_cnt,
    input  logic             halt_clr,
    output logic             halted
);

    seq_state_e       r_state;
    logic             r_rspValid;
    op_e              r_rspOp;
    logic [7:0]       r_rspRes;
    logic             r_rspZero;
    logic             r_rspOvf;
    logic             r_rspCout;
    logic [CNT_W-1:0] r_issuedCnt;
`ifdef CU_OVF_HALT_EN
    logic             r_halted;
`endif

    cu_cmd_t          w_pushCmd;
    cu_cmd_t          w_head;
    logic [1:0]       w_headOpBits;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_issue;
    logic             w_rspFree;
    logic [7:0]       w_res;
    logic             w_zero;
    logic             w_ovf;
    logic             w_cout;
    logic             w_unused;

    // control_unit recomputes zero/overflow itself; those copies are not needed
    // here because the flags are derived from the captured result instead.
`ifdef CU_OVF_HALT_EN
    assign w_unused = ^{cu_zero, cu_ovf};
`else
    assign w_unused = ^{cu_zero, cu_ovf, halt_clr};
`endif

    assign w_pushCmd = '{op: op_e'(cmd_op), a: cmd_a, b: cmd_b};

    // cmd_ready depends only on FIFO state, never on cmd_valid.
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    cu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_pushCmd),
        .i_pop   (w_issue),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // The head is already zeroed by the FIFO when empty, so the control_unit
    // sees all-zero inputs whenever nothing is pending.
    assign w_headOpBits = w_head.op;
    assign cu_ctrl1     = w_headOpBits[1];
    assign cu_ctrl0     = w_headOpBits[0];
    assign cu_a         = w_head.a;
    assign cu_b         = w_head.b;

    // Flags for the value about to be captured, tied to the head's operation.
    assign w_res  = {cu_resh, cu_resl};
    assign w_zero = (w_res == 8'h00);
    assign w_ovf  = (w_head.op != OP_AND) && !sign_fits(cu_resh, cu_resl[3]);
    assign w_cout = op_has_carry(w_head.op) && cu_cout;

    // Issue when a command waits and the response slot is empty or being drained.
    assign w_rspFree = !r_rspValid || rsp_ready;
    assign w_issue   = (r_state == RUN) && !w_empty && w_rspFree;

    // Sequencer FSM with the response register and issue counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_rspValid  <= 1'b0;
            r_rspOp     <= OP_ADD;
            r_rspRes    <= '0;
            r_rspZero   <= 1'b0;
            r_rspOvf    <= 1'b0;
            r_rspCout   <= 1'b0;
            r_issuedCnt <= '0;
`ifdef CU_OVF_HALT_EN
            r_halted    <= 1'b0;
`endif
        end else begin
            if (w_issue) begin
                r_rspValid  <= 1'b1;
                r_rspOp     <= w_head.op;
                r_rspRes    <= w_res;
                r_rspZero   <= w_zero;
                r_rspOvf    <= w_ovf;
                r_rspCout   <= w_cout;
                r_issuedCnt <= r_issuedCnt + CNT_W'(1);
            end else if (rsp_ready) begin
                r_rspValid  <= 1'b0;
            end

            unique case (r_state)
                RUN: begin
`ifdef CU_OVF_HALT_EN
                    if (w_issue && w_ovf) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
`endif
                end
                HALT: begin
`ifdef CU_OVF_HALT_EN
                    if (halt_clr) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
`else
                    r_state <= RUN;
`endif
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rspValid;
    assign rsp_op     = r_rspOp;
    assign rsp_res    = r_rspRes;
    assign rsp_zero   = r_rspZero;
    assign rsp_ovf    = r_rspOvf;
    assign rsp_cout   = r_rspCout;
    assign issued_cnt = r_issuedCnt;

`ifdef CU_OVF_HALT_EN
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

endmodule
